// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-granular round-robin arbiter from NUM_SRC AXI-Stream inputs onto one output
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int BURST_MAX  = 256
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          arb_en,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]            S_AXIS_TVALID,
    input  logic [NUM_SRC-1:0]            S_AXIS_TLAST,
    output logic [NUM_SRC-1:0]            S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    output logic [DATA_WIDTH/8-1:0]       M_AXIS_TSTRB,
    output logic                          M_AXIS_TLAST,
    input  logic                          M_AXIS_TREADY,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int CW = $clog2(BURST_MAX);
    localparam logic [CW-1:0] BEAT_LAST = CW'(BURST_MAX - 1);
    localparam logic [GW-1:0] GRANT_RST = GW'(NUM_SRC - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d, rr_pick;
    logic [CW-1:0]           beat_q, beat_d;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    sel_last;
    logic                    handshake;

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (GW'(i) == grant_q) begin
                sel_data  = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = S_AXIS_TVALID[i];
                sel_last  = S_AXIS_TLAST[i];
            end
        end
    end

    // Scan from the farthest offset down so the nearest valid source after grant_q wins.
    always_comb begin
        rr_pick = grant_q;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (S_AXIS_TVALID[GW'((int'(grant_q) + k) % NUM_SRC)]) begin
                rr_pick = GW'((int'(grant_q) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        busy          = (state_q == GRANT);
        grant_id      = grant_q;
        M_AXIS_TSTRB  = '1;
        M_AXIS_TDATA  = sel_data;
        M_AXIS_TVALID = busy & sel_valid;
        M_AXIS_TLAST  = busy & (sel_last | (beat_q == BEAT_LAST));
        S_AXIS_TREADY = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (GW'(i) == grant_q) begin
                S_AXIS_TREADY[i] = busy & M_AXIS_TREADY;
            end
        end
        handshake = M_AXIS_TVALID & M_AXIS_TREADY;
    end

    // grant_q is kept across IDLE so the next scan starts after the last owner.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (arb_en && (|S_AXIS_TVALID)) begin
                    state_d = GRANT;
                    grant_d = rr_pick;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (handshake) begin
                    if (M_AXIS_TLAST) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            grant_q <= GRANT_RST;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - randomized scoreboard bench for axis_rr_arbiter
module tb_axis_rr_arbiter;

    localparam int DW = 32;
    localparam int NS = 4;
    localparam int BM = 4;
    localparam int GW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [GW-1:0] src;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic               ACLK;
    logic               ARESETn;
    logic               arb_en;
    logic [NS*DW-1:0]   S_AXIS_TDATA;
    logic [NS-1:0]      S_AXIS_TVALID;
    logic [NS-1:0]      S_AXIS_TLAST;
    logic [NS-1:0]      S_AXIS_TREADY;
    logic [DW-1:0]      M_AXIS_TDATA;
    logic               M_AXIS_TVALID;
    logic [DW/8-1:0]    M_AXIS_TSTRB;
    logic               M_AXIS_TLAST;
    logic               M_AXIS_TREADY;
    logic [GW-1:0]      grant_id;
    logic               busy;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .BURST_MAX(BM)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .arb_en(arb_en),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TREADY(M_AXIS_TREADY), .grant_id(grant_id), .busy(busy)
    );

    beat_t srcq[NS][$];
    beat_t mq[NS][$];
    exp_t  expq[$];
    int    m_last = NS - 1;
    int    hold[NS] = '{default: 0};
    int    tr_mode = 0;
    bit    gap_en = 0;
    logic [NS-1:0] watch_mask = '0;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    hs_cnt = 0;
    int    last_hs = 0;
    int    pkt_id = 0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        #2;
    endtask

    task automatic load_pkt(input int s, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = {8'(s), 8'(pkt_id), 16'($urandom)};
            b.last = (k == n - 1);
            srcq[s].push_back(b);
            mq[s].push_back(b);
        end
        pkt_id++;
    endtask

    // Reference: each grant goes to the first source after the previous owner that
    // still has queued beats; it delivers up to BM beats, ending early on its own TLAST.
    function automatic void predict(input int max_grants);
        int    pick;
        int    n;
        int    g;
        beat_t b;
        exp_t  e;
        g = 0;
        while (g < max_grants) begin
            pick = -1;
            for (int k = 1; k <= NS; k++) begin
                if (pick < 0 && mq[(m_last + k) % NS].size() > 0) pick = (m_last + k) % NS;
            end
            if (pick < 0) break;
            n = 0;
            do begin
                b = mq[pick].pop_front();
                n++;
                e.src  = GW'(pick);
                e.data = b.data;
                e.last = b.last || (n == BM);
                expq.push_back(e);
            end while (!e.last);
            m_last = pick;
            g++;
        end
    endfunction

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (expq.size() > 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk(expq.size() == 0, "drain_timeout", expq.size(), 0);
    endtask

    task automatic wait_hs(input int max_cyc);
        int base;
        int n;
        base = hs_cnt;
        n = 0;
        while (hs_cnt == base && n < max_cyc) begin
            tick();
            n++;
        end
        chk(hs_cnt != base, "first_beat_timeout", n, max_cyc);
    endtask

    task automatic chk_idle(input string name);
        chk(!busy && !M_AXIS_TVALID && S_AXIS_TREADY == '0, name,
            {busy, M_AXIS_TVALID, S_AXIS_TREADY}, 0);
    endtask

    // Source drivers and sink ready
    initial begin
        logic [NS-1:0] acc;
        bit gap;
        S_AXIS_TDATA  = '0;
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        M_AXIS_TREADY = 1'b0;
        forever begin
            @(negedge ACLK);
            acc = ARESETn ? (S_AXIS_TVALID & S_AXIS_TREADY) : '0;
            @(posedge ACLK);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                gap = gap_en && busy && (grant_id == GW'(i)) && ($urandom_range(0, 3) == 0);
                if (hold[i] > 0) begin
                    S_AXIS_TVALID[i] = 1'b0;
                    hold[i]--;
                end else if (srcq[i].size() > 0 && !gap) begin
                    S_AXIS_TVALID[i]           = 1'b1;
                    S_AXIS_TDATA[i*DW +: DW]   = srcq[i][0].data;
                    S_AXIS_TLAST[i]            = srcq[i][0].last;
                end else begin
                    S_AXIS_TVALID[i] = 1'b0;
                    S_AXIS_TLAST[i]  = 1'b0;
                end
            end
            case (tr_mode)
                0:       M_AXIS_TREADY = 1'b1;
                1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
                default: M_AXIS_TREADY = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESETn && watch_mask != '0)
                chk((S_AXIS_TREADY & watch_mask) == '0, "stalled_src_ready", S_AXIS_TREADY, 0);
            if (ARESETn && M_AXIS_TVALID && M_AXIS_TREADY) begin
                hs_cnt++;
                last_hs = cyc;
                if (expq.size() == 0) begin
                    chk(1'b0, "unexpected_beat", {grant_id, M_AXIS_TDATA}, 0);
                end else begin
                    e = expq.pop_front();
                    chk({grant_id, M_AXIS_TDATA, M_AXIS_TLAST} == {e.src, e.data, e.last}, "beat",
                        {grant_id, M_AXIS_TDATA, M_AXIS_TLAST}, {e.src, e.data, e.last});
                    chk(S_AXIS_TREADY == (4'b0001 << e.src), "src_ready_onehot",
                        S_AXIS_TREADY, 4'b0001 << e.src);
                end
            end
        end
    end

    initial begin
        int first_hs;
        bit loaded;
        ARESETn = 1'b0;
        arb_en  = 1'b1;
        repeat (3) @(posedge ACLK);
        tick();
        chk_idle("reset_idle");
        chk(grant_id == GW'(NS - 1), "reset_grant_id", grant_id, NS - 1);
        chk(M_AXIS_TSTRB == '1 && !M_AXIS_TLAST, "reset_strb_last", {M_AXIS_TSTRB, M_AXIS_TLAST}, 5'h1e);
        ARESETn = 1'b1;

        // All four sources, 3-beat packets, sink always ready
        for (int s = 0; s < NS; s++) load_pkt(s, 3);
        predict(99);
        wait_hs(20);
        first_hs = last_hs;
        drain(200);
        chk(last_hs - first_hs == 14, "packet_gap_span", last_hs - first_hs, 14);
        chk(grant_id == 2'd3, "final_grant_id", grant_id, 3);

        // Single source, toggling sink ready
        tr_mode = 1;
        watch_mask = 4'b1011;
        load_pkt(2, 5);
        predict(99);
        drain(200);
        watch_mask = '0;
        tr_mode = 0;

        // Forced last every BM beats, interleaved with source 0
        load_pkt(1, 10);
        load_pkt(0, 2);
        load_pkt(0, 2);
        predict(99);
        drain(300);

        // arb_en gating
        tick();
        arb_en = 1'b0;
        load_pkt(0, 5);
        load_pkt(3, 5);
        repeat (10) begin
            tick();
            chk_idle("arb_dis_idle");
        end
        arb_en = 1'b1;
        predict(1);
        wait_hs(20);
        arb_en = 1'b0;
        drain(200);
        tick();
        repeat (8) begin
            tick();
            chk_idle("arb_drop_idle");
        end
        arb_en = 1'b1;
        predict(99);
        drain(200);

        // Reset in the middle of a packet
        load_pkt(0, 6);
        predict(99);
        wait_hs(20);
        @(posedge ACLK);
        #2;
        ARESETn = 1'b0;
        @(posedge ACLK);
        tick();
        chk_idle("midpkt_reset_idle");
        chk(grant_id == GW'(NS - 1), "midpkt_reset_grant", grant_id, NS - 1);
        for (int s = 0; s < NS; s++) begin
            srcq[s].delete();
            mq[s].delete();
        end
        expq.delete();
        m_last = NS - 1;
        tick();
        ARESETn = 1'b1;
        load_pkt(2, 3);
        load_pkt(0, 2);
        predict(99);
        drain(200);

        // Granted source pauses mid-packet while another waits
        load_pkt(1, 4);
        predict(99);
        wait_hs(20);
        hold[1] = 3;
        load_pkt(2, 3);
        predict(99);
        repeat (3) begin
            tick();
            chk(!M_AXIS_TVALID && busy && grant_id == 2'd1, "tvalid_gap_hold",
                {M_AXIS_TVALID, busy, grant_id}, 4'b0101);
        end
        drain(200);

        // Randomized rounds
        tr_mode = 2;
        gap_en = 1'b1;
        repeat (25) begin
            loaded = 1'b0;
            for (int s = 0; s < NS; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 2)) load_pkt(s, $urandom_range(1, 6));
                    loaded = 1'b1;
                end
            end
            if (!loaded) load_pkt($urandom_range(0, NS - 1), $urandom_range(1, 6));
            predict(999);
            drain(3000);
        end
        gap_en = 1'b0;
        repeat (5) tick();
        chk(expq.size() == 0 && hs_cnt > 0, "final_scoreboard_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
